// File: rtl/prim_rom_req_adapter.sv
// prim_rom_req_adapter
//
// Valid/ready front-end for a single-cycle registered ROM macro that has only
// req/addr inputs and no backpressure. Requests are accepted on a credit basis,
// forwarded to the ROM in the accept cycle, and the read data (or an error
// tag for out-of-range addresses) is captured one cycle later into a small
// response FIFO. The consumer can stall indefinitely without losing data.
//
// Parameters
//   Width     data width, equal to the ROM word width
//   Depth     number of ROM words (>= 2, need not be a power of two)
//   RspDepth  response FIFO entries (>= 2; 2 sustains one request per cycle)
//
// Ports
//   clk_i        clock, all state on the rising edge
//   rst_ni       synchronous active-low reset
//   req_valid_i  request valid
//   req_ready_o  request ready (credit available)
//   req_addr_i   word address
//   rsp_valid_o  response valid (FIFO not empty)
//   rsp_ready_i  response ready
//   rsp_rdata_o  read data of the head response, 0 on error or when empty
//   rsp_err_o    head response addressed a word >= Depth
//   rom_req_o    ROM read strobe
//   rom_addr_o   ROM word address (mirrors req_addr_i)
//   rom_rdata_i  ROM read data, valid the cycle after rom_req_o

module prim_rom_req_adapter #(
  parameter int Width    = 32,
  parameter int Depth    = 2048,
  parameter int RspDepth = 2,
  localparam int Aw      = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [Aw-1:0]    req_addr_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [Width-1:0] rsp_rdata_o,
  output logic             rsp_err_o,
  output logic             rom_req_o,
  output logic [Aw-1:0]    rom_addr_o,
  input  logic [Width-1:0] rom_rdata_i
);

  localparam int CntW = $clog2(RspDepth + 1);
  localparam int PtrW = $clog2(RspDepth);

  // Advance a FIFO pointer, wrapping at RspDepth (which need not be a power
  // of two, so plain overflow of the pointer is not enough).
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(RspDepth - 1)) begin
      return '0;
    end
    return p + PtrW'(1);
  endfunction

  logic             acc;
  logic             pop;
  logic             push;
  logic             in_range;
  logic [CntW:0]    occ;

  logic             vld_p1;
  logic             err_p1;

  logic [CntW-1:0]  cnt;
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [Width-1:0] mem_data [RspDepth];
  logic             mem_err  [RspDepth];

  // Stage p0: accept and issue to the ROM.
  // A request may only be accepted if its response is guaranteed a FIFO slot
  // when it lands: entries already buffered plus the one in flight, minus the
  // one leaving this cycle, must leave room. The pop term creates a
  // combinational path from rsp_ready_i to req_ready_o, which is what allows
  // full throughput with only two entries.
  assign in_range    = ({1'b0, req_addr_i} < (Aw + 1)'(Depth));
  assign occ         = {1'b0, cnt} + (CntW + 1)'(vld_p1) - (CntW + 1)'(pop);
  assign req_ready_o = rst_ni & (occ < (CntW + 1)'(RspDepth));
  assign acc         = req_valid_i & req_ready_o;

  // Out-of-range requests never touch the ROM; they travel the same pipeline
  // as a normal read so that responses stay in order with fixed latency.
  assign rom_req_o   = acc & in_range;
  assign rom_addr_o  = req_addr_i;

  // Stage p1: ROM data valid, written into the FIFO at the end of this cycle.
  assign push = vld_p1;

  // Stage p2: FIFO head presented to the consumer.
  assign rsp_valid_o = rst_ni & (cnt != '0);
  assign pop         = rsp_valid_o & rsp_ready_i;
  assign rsp_rdata_o = rsp_valid_o ? mem_data[rd_ptr] : '0;
  assign rsp_err_o   = rsp_valid_o ? mem_err[rd_ptr]  : 1'b0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_p1 <= 1'b0;
      err_p1 <= 1'b0;
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < RspDepth; i++) begin
        mem_data[i] <= '0;
        mem_err[i]  <= 1'b0;
      end
    end else begin
      vld_p1 <= acc;
      err_p1 <= acc & ~in_range;

      if (push) begin
        // The ROM output is stale for error entries, so force the data to 0.
        mem_data[wr_ptr] <= err_p1 ? '0 : rom_rdata_i;
        mem_err[wr_ptr]  <= err_p1;
        wr_ptr           <= ptr_inc(wr_ptr);
      end

      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end

      unique case ({push, pop})
        2'b10:   cnt <= cnt + CntW'(1);
        2'b01:   cnt <= cnt - CntW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Interface and internal-consistency checks.
  a_no_x_ctrl : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !$isunknown({req_valid_i, rsp_ready_i}));

  a_addr_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (req_valid_i && !req_ready_o) |=> (!req_valid_i || $stable(req_addr_i)));

  a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && (cnt == CntW'(RspDepth))));

  a_cnt_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
    cnt <= CntW'(RspDepth));

endmodule

// File: tb/tb_prim_rom_req_adapter.sv
module tb_prim_rom_req_adapter;

  localparam int WIDTH = 32;
  localparam int DEPTH = 1000;
  localparam int RSPD  = 2;
  localparam int AW    = $clog2(DEPTH);

  logic             clk_i;
  logic             rst_ni;
  logic             req_valid_i;
  logic             req_ready_o;
  logic [AW-1:0]    req_addr_i;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [WIDTH-1:0] rsp_rdata_o;
  logic             rsp_err_o;
  logic             rom_req_o;
  logic [AW-1:0]    rom_addr_o;
  logic [WIDTH-1:0] rom_rdata_i;

  prim_rom_req_adapter #(
    .Width    (WIDTH),
    .Depth    (DEPTH),
    .RspDepth (RSPD)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .rom_req_o   (rom_req_o),
    .rom_addr_o  (rom_addr_o),
    .rom_rdata_i (rom_rdata_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // ROM contents and a behavioural single-cycle ROM. Request is latched at
  // the negedge so the posedge update never races the DUT's own flops.
  logic [WIDTH-1:0] rom_mem [DEPTH];
  logic             rom_req_s;
  logic [AW-1:0]    rom_addr_s;

  initial begin
    for (int i = 0; i < DEPTH; i++) rom_mem[i] = (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
    rom_mem[5]   = 32'hDEADBEEF;
    rom_mem[999] = 32'hCAFEF00D;
  end

  always @(negedge clk_i) begin
    rom_req_s  <= rom_req_o;
    rom_addr_s <= rom_addr_o;
  end

  always @(posedge clk_i) begin
    if (rom_req_s) rom_rdata_i <= rom_mem[rom_addr_s];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic             err;
    logic [WIDTH-1:0] data;
    int               acc_cyc;
  } exp_t;

  exp_t exp_q[$];

  int acc_total = 0;
  int stall_cnt = 0;
  int pop_total = 0;
  int pop_gaps  = 0;
  int last_pop  = -10;

  // Issue one request: hold valid/addr until accepted, then push the expected
  // response. Called #1 after a rising edge; returns #1 after the accept edge.
  task automatic issue(input logic [AW-1:0] a);
    int   w;
    exp_t e;
    w = 0;
    req_valid_i = 1'b1;
    req_addr_i  = a;
    forever begin
      @(negedge clk_i);
      if (req_ready_o) begin
        e.err     = (int'(a) >= DEPTH);
        e.data    = e.err ? '0 : rom_mem[int'(a)];
        e.acc_cyc = cyc;
        exp_q.push_back(e);
        acc_total++;
        break;
      end
      stall_cnt++;
      w++;
      if (w > 200) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: addr %0d not accepted within 200 cycles", a);
        break;
      end
      @(posedge clk_i);
      #1;
    end
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
  endtask

  // Monitor: checks control outputs every cycle and pops the scoreboard
  // whenever the DUT presents a response.
  int               outs = 0;
  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data;
  logic             prev_err;

  always @(negedge clk_i) begin
    logic pop_now;
    logic acc_now;
    exp_t e;
    if (!rst_ni) begin
      chk("reset_outputs", {req_ready_o, rom_req_o, rsp_valid_o, rsp_err_o, rsp_rdata_o}, '0);
      exp_q.delete();
      outs       = 0;
      prev_stall = 1'b0;
    end else begin
      pop_now = rsp_valid_o && rsp_ready_i;
      acc_now = req_valid_i && req_ready_o;
      chk("req_ready_credit", req_ready_o, ((outs - int'(pop_now)) < RSPD));
      chk("rom_req", rom_req_o, acc_now && (int'(req_addr_i) < DEPTH));
      chk("rom_addr", rom_addr_o, req_addr_i);
      if (prev_stall) begin
        chk("rsp_stable", {rsp_valid_o, rsp_err_o, rsp_rdata_o}, {1'b1, prev_err, prev_data});
      end
      if (exp_q.size() > 0 && exp_q[0].acc_cyc + 2 <= cyc) begin
        chk("rsp_valid_due", rsp_valid_o, 1'b1);
      end
      if (rsp_valid_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got data %0h err %0b expected no response", rsp_rdata_o, rsp_err_o);
        end else begin
          e = exp_q[0];
          chk("rsp_not_early", (cyc >= e.acc_cyc + 2), 1'b1);
          chk("rsp_data", rsp_rdata_o, e.data);
          chk("rsp_err", rsp_err_o, e.err);
          if (pop_now) begin
            void'(exp_q.pop_front());
            pop_total++;
            if (last_pop != cyc - 1) pop_gaps++;
            last_pop = cyc;
          end
        end
      end else begin
        chk("rsp_idle_zero", {rsp_err_o, rsp_rdata_o}, '0);
      end
      outs       = outs + int'(acc_now) - int'(pop_now);
      prev_stall = rsp_valid_o && !rsp_ready_i;
      prev_data  = rsp_rdata_o;
      prev_err   = rsp_err_o;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic wait_drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(posedge clk_i);
      w++;
    end
    #1;
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    int  base, s0, p0, g0;
    logic done;

    // Reset held 3 cycles with a request pending.
    rst_ni      = 1'b0;
    req_valid_i = 1'b1;
    req_addr_i  = AW'(5);
    rsp_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni      = 1'b1;
    req_valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;

    // Single read with exact latency.
    rsp_ready_i = 1'b1;
    issue(AW'(5));
    @(negedge clk_i);
    chk("single_n1_valid", rsp_valid_o, 1'b0);
    @(negedge clk_i);
    chk("single_n2", {rsp_valid_o, rsp_err_o, rsp_rdata_o}, {1'b1, 1'b0, 32'hDEADBEEF});
    wait_drain();

    // Streaming 0..15.
    s0 = stall_cnt;
    p0 = pop_total;
    g0 = pop_gaps;
    for (int a = 0; a < 16; a++) issue(AW'(a));
    repeat (4) @(posedge clk_i);
    #1;
    chk("stream_no_stall", stall_cnt - s0, 0);
    chk("stream_pops", pop_total - p0, 16);
    chk("stream_consecutive", (pop_gaps - g0) <= 1, 1'b1);

    // Backpressure: only two requests fit.
    rsp_ready_i = 1'b0;
    base = acc_total;
    fork
      begin
        issue(AW'(1));
        issue(AW'(2));
        issue(AW'(3));
      end
      begin
        repeat (6) @(negedge clk_i);
        chk("bp_ready_low", req_ready_o, 1'b0);
        chk("bp_accepted", acc_total - base, 2);
        @(posedge clk_i);
        #1;
        rsp_ready_i = 1'b1;
      end
    join
    wait_drain();
    chk("bp_total", acc_total - base, 3);

    // Range error followed by the last valid word.
    issue(AW'(1000));
    issue(AW'(999));
    @(negedge clk_i);
    chk("err_rsp", {rsp_valid_o, rsp_err_o, rsp_rdata_o}, {1'b1, 1'b1, 32'h0});
    @(negedge clk_i);
    chk("last_word_rsp", {rsp_valid_o, rsp_err_o, rsp_rdata_o}, {1'b1, 1'b0, 32'hCAFEF00D});
    wait_drain();

    // Reset with one response buffered and one in flight.
    rsp_ready_i = 1'b0;
    issue(AW'(10));
    issue(AW'(11));
    rst_ni = 1'b0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      chk("post_reset_idle", rsp_valid_o, 1'b0);
    end
    @(posedge clk_i);
    #1;
    rsp_ready_i = 1'b1;
    issue(AW'(12));
    wait_drain();

    // Randomized traffic with random consumer stalls.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk_i);
            #1;
          end
          issue(AW'($urandom_range(0, 1023)));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk_i);
          #1;
          rsp_ready_i = ($urandom_range(0, 3) != 0);
        end
      end
    join
    rsp_ready_i = 1'b1;
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
